reg_file_mp: RTL and testbench

//  Parametrised multi-read register file; the next-generation replacement for the 16-entry 8-bit core file.

---
 rtl/reg_file_pkg.sv | 21 ++
 rtl/reg_file_clr_seq.sv | 78 +++++++
 rtl/reg_file_mp.sv | 134 +++++++++++++
 tb/tb_reg_file_mp.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// ============================================================================
//  Module   : reg_file_pkg
//  Brief    : Shared types and default sizing for the multi-port register file.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

   typedef enum logic [1:0] {
      CLR_IDLE  = 2'd0,
      CLR_SWEEP = 2'd1,
      CLR_DONE  = 2'd2
   } clr_state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

endpackage : reg_file_pkg

`default_nettype wire

// File: rtl/reg_file_clr_seq.sv
// ============================================================================
//  Module   : reg_file_clr_seq
//  Brief    : Background clear sequencer; walks a pointer over every entry,
//             issuing one zero-write per cycle, then pulses clr_done.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_clr_seq
   import reg_file_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_req,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr,
   output logic          clr_busy,
   output logic          clr_done
);

   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   clr_state_t    state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         CLR_IDLE: begin
            if (clr_req) begin
               state_d = CLR_SWEEP;
               ptr_d   = '0;
            end
         end
         CLR_SWEEP: begin
            if (ptr_q == LAST_PTR) begin
               state_d = CLR_DONE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + AW'(1);
            end
         end
         CLR_DONE: state_d = CLR_IDLE;
         default:  state_d = CLR_IDLE;
      endcase
      // Status flags are decoded from the next state so they leave a flop.
      busy_d = (state_d == CLR_SWEEP);
      done_d = (state_d == CLR_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CLR_IDLE;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign clr_we   = (state_q == CLR_SWEEP);
   assign clr_addr = ptr_q;
   assign clr_busy = busy_q;
   assign clr_done = done_q;

endmodule : reg_file_clr_seq

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
//  Module   : reg_file_mp
//  Brief    : Parametrised two-read / one-write register file with optional
//             zero register, write bypass, registered reads and background clear.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int AW      = $clog2(DEPTH),
   parameter int RD_LAT  = 0,
   parameter int BYPASS  = 1,
   parameter int R0_ZERO = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rda_addr,
   input  logic [AW-1:0]    rdb_addr,
   output logic [WIDTH-1:0] rda_data,
   output logic [WIDTH-1:0] rdb_data,
   input  logic             clr_req,
   output logic             clr_busy,
   output logic             clr_done
);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic             clr_we;
   logic [AW-1:0]    clr_addr;
   logic             wr_valid;
   logic             byp_a, byp_b;
   logic [WIDTH-1:0] rda_d, rdb_d;

   reg_file_clr_seq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clr_seq (
      .clk      (clk),
      .reset    (reset),
      .clr_req  (clr_req),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .clr_busy (clr_busy),
      .clr_done (clr_done)
   );

   // Storage update: the user write is applied after the sweep zero so it wins.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = regs_q[i];
         if (clr_we && (clr_addr == AW'(i))) begin
            regs_d[i] = '0;
         end
         if (wr_en && (wr_addr == AW'(i))) begin
            regs_d[i] = wr_data;
         end
         if ((R0_ZERO != 0) && (i == 0)) begin
            regs_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // An address at or beyond DEPTH matches no entry, so it reads 0 and never bypasses.
   always_comb begin
      wr_valid = 1'b0;
      rda_d    = '0;
      rdb_d    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_addr == AW'(i)) begin
            wr_valid = 1'b1;
         end
         if (rda_addr == AW'(i)) begin
            rda_d = regs_q[i];
         end
         if (rdb_addr == AW'(i)) begin
            rdb_d = regs_q[i];
         end
      end
      byp_a = (BYPASS != 0) && wr_en && wr_valid && (wr_addr == rda_addr);
      byp_b = (BYPASS != 0) && wr_en && wr_valid && (wr_addr == rdb_addr);
      if (byp_a) begin
         rda_d = wr_data;
      end
      if (byp_b) begin
         rdb_d = wr_data;
      end
      if ((R0_ZERO != 0) && (rda_addr == '0)) begin
         rda_d = '0;
      end
      if ((R0_ZERO != 0) && (rdb_addr == '0)) begin
         rdb_d = '0;
      end
   end

   if (RD_LAT == 1) begin : g_rd_reg
      logic [WIDTH-1:0] rda_q, rdb_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            rda_q <= '0;
            rdb_q <= '0;
         end else begin
            rda_q <= rda_d;
            rdb_q <= rdb_d;
         end
      end

      assign rda_data = rda_q;
      assign rdb_data = rdb_q;
   end else begin : g_rd_comb
      assign rda_data = rda_d;
      assign rdb_data = rdb_d;
   end

endmodule : reg_file_mp

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// ============================================================================
//  Module   : tb_reg_file_mp
//  Brief    : Self-checking bench for reg_file_mp across four configurations.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_mp;

   localparam int NI = 4;

   // Instance configurations: 0 default, 1 DEPTH=12 no bypass, 2 registered reads, 3 zero register
   int dep_c [NI] = '{16, 12, 16, 16};
   bit lat_c [NI] = '{0, 0, 1, 0};
   bit byp_c [NI] = '{1, 0, 1, 1};
   bit r0_c  [NI] = '{0, 0, 0, 1};

   logic       clk = 1'b0;
   logic       reset, wr_en, clr_req;
   logic [3:0] wr_addr, rda_addr, rdb_addr;
   logic [7:0] wr_data;
   logic [7:0] rda_w [NI];
   logic [7:0] rdb_w [NI];
   logic       busy_w [NI];
   logic       done_w [NI];

   always #5 clk = ~clk;

   reg_file_mp #(.WIDTH(8), .DEPTH(16), .RD_LAT(0), .BYPASS(1), .R0_ZERO(0)) u0 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rda_addr(rda_addr), .rdb_addr(rdb_addr), .rda_data(rda_w[0]), .rdb_data(rdb_w[0]),
      .clr_req(clr_req), .clr_busy(busy_w[0]), .clr_done(done_w[0]));
   reg_file_mp #(.WIDTH(8), .DEPTH(12), .RD_LAT(0), .BYPASS(0), .R0_ZERO(0)) u1 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rda_addr(rda_addr), .rdb_addr(rdb_addr), .rda_data(rda_w[1]), .rdb_data(rdb_w[1]),
      .clr_req(clr_req), .clr_busy(busy_w[1]), .clr_done(done_w[1]));
   reg_file_mp #(.WIDTH(8), .DEPTH(16), .RD_LAT(1), .BYPASS(1), .R0_ZERO(0)) u2 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rda_addr(rda_addr), .rdb_addr(rdb_addr), .rda_data(rda_w[2]), .rdb_data(rdb_w[2]),
      .clr_req(clr_req), .clr_busy(busy_w[2]), .clr_done(done_w[2]));
   reg_file_mp #(.WIDTH(8), .DEPTH(16), .RD_LAT(0), .BYPASS(1), .R0_ZERO(1)) u3 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rda_addr(rda_addr), .rdb_addr(rdb_addr), .rda_data(rda_w[3]), .rdb_data(rdb_w[3]),
      .clr_req(clr_req), .clr_busy(busy_w[3]), .clr_done(done_w[3]));

   // Reference model: entry contents plus the edge index at which a clear was accepted.
   // A clear accepted at edge s zeroes entry k at edge s+1+k; busy spans DEPTH cycles, done the next one.
   logic [7:0] mem [NI][16];
   int         start_e [NI];
   bit         active [NI];
   logic [7:0] lat_a [NI];
   logic [7:0] lat_b [NI];
   int         edges;

   int checks = 0;
   int errors = 0;

   logic [7:0] cap_a [NI];
   logic [7:0] cap_b [NI];
   logic       cap_busy [NI];
   logic       cap_done [NI];

   typedef struct {
      logic       rst;
      logic       we;
      logic [3:0] wa;
      logic [7:0] wd;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [7:0] ea0;
      logic [7:0] eb0;
      logic [7:0] ea1;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] comb_rd(input int i, input logic [3:0] a);
      if (int'(a) >= dep_c[i]) return 8'h00;
      if (r0_c[i] && a == 4'd0) return 8'h00;
      if (byp_c[i] && wr_en && wr_addr == a) return wr_data;
      return mem[i][a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         for (int j = 0; j < 16; j++) mem[i][j] = 8'h00;
         active[i]  = 1'b0;
         start_e[i] = 0;
         lat_a[i]   = 8'h00;
         lat_b[i]   = 8'h00;
      end
   endtask

   task automatic model_check();
      int  k;
      bit  eb, ed;
      for (int i = 0; i < NI; i++) begin
         k  = edges - 1 - start_e[i];
         eb = active[i] && k >= 0 && k < dep_c[i];
         ed = active[i] && k == dep_c[i];
         chk($sformatf("busy u%0d", i), 8'(cap_busy[i]), 8'(eb));
         chk($sformatf("done u%0d", i), 8'(cap_done[i]), 8'(ed));
         chk($sformatf("rda u%0d addr %0d", i, rda_addr), cap_a[i],
             lat_c[i] ? lat_a[i] : comb_rd(i, rda_addr));
         chk($sformatf("rdb u%0d addr %0d", i, rdb_addr), cap_b[i],
             lat_c[i] ? lat_b[i] : comb_rd(i, rdb_addr));
      end
   endtask

   task automatic model_edge();
      logic [7:0] la, lb;
      int         k;
      for (int i = 0; i < NI; i++) begin
         la = comb_rd(i, rda_addr);
         lb = comb_rd(i, rdb_addr);
         if (reset) begin
            for (int j = 0; j < 16; j++) mem[i][j] = 8'h00;
            active[i] = 1'b0;
            lat_a[i]  = 8'h00;
            lat_b[i]  = 8'h00;
         end else begin
            lat_a[i] = la;
            lat_b[i] = lb;
            k = edges - 1 - start_e[i];
            if (active[i] && k >= dep_c[i] + 1) active[i] = 1'b0;
            if (active[i] && k >= 0 && k < dep_c[i]) mem[i][k] = 8'h00;
            if (wr_en && int'(wr_addr) < dep_c[i] && !(r0_c[i] && wr_addr == 4'd0))
               mem[i][wr_addr] = wr_data;
            if (clr_req && !active[i]) begin
               active[i]  = 1'b1;
               start_e[i] = edges;
            end
         end
      end
      edges++;
   endtask

   // One clock cycle: drive, sample and check at negedge, advance the model at posedge.
   task automatic cycle(input logic rst, input logic we, input logic [3:0] wa, input logic [7:0] wd,
                        input logic [3:0] ra, input logic [3:0] rb, input logic cr);
      reset    = rst;
      wr_en    = we;
      wr_addr  = wa;
      wr_data  = wd;
      rda_addr = ra;
      rdb_addr = rb;
      clr_req  = cr;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         cap_a[i]    = rda_w[i];
         cap_b[i]    = rdb_w[i];
         cap_busy[i] = busy_w[i];
         cap_done[i] = done_w[i];
      end
      model_check();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic fill();
      for (int a = 0; a < 16; a++) cycle(1'b0, 1'b1, 4'(a), 8'(a + 1), 4'd0, 4'd0, 1'b0);
   endtask

   initial begin
      int busy_cnt, done_cnt, done_at;

      tbl[0] = '{1'b1, 1'b0, 4'd0,  8'h00, 4'd0,  4'd0,  8'h00, 8'h00, 8'h00};
      tbl[1] = '{1'b0, 1'b1, 4'd3,  8'h5A, 4'd3,  4'd4,  8'h5A, 8'h00, 8'h00};
      tbl[2] = '{1'b0, 1'b0, 4'd0,  8'h00, 4'd3,  4'd4,  8'h5A, 8'h00, 8'h5A};
      tbl[3] = '{1'b0, 1'b1, 4'd7,  8'hC3, 4'd7,  4'd3,  8'hC3, 8'h5A, 8'h00};
      tbl[4] = '{1'b0, 1'b0, 4'd0,  8'h00, 4'd7,  4'd3,  8'hC3, 8'h5A, 8'hC3};
      tbl[5] = '{1'b0, 1'b1, 4'd12, 8'h77, 4'd12, 4'd12, 8'h77, 8'h77, 8'h00};
      tbl[6] = '{1'b0, 1'b1, 4'd15, 8'h99, 4'd12, 4'd15, 8'h77, 8'h99, 8'h00};
      tbl[7] = '{1'b0, 1'b0, 4'd0,  8'h00, 4'd12, 4'd15, 8'h77, 8'h99, 8'h00};

      reset = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
      rda_addr = 4'd0; rdb_addr = 4'd0; clr_req = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      edges = 0;

      // Directed table: reset state, write/read, bypass vs no bypass, out-of-range writes
      for (int v = 0; v < 8; v++) begin
         cycle(tbl[v].rst, tbl[v].we, tbl[v].wa, tbl[v].wd, tbl[v].ra, tbl[v].rb, 1'b0);
         chk($sformatf("table %0d rda u0", v), cap_a[0], tbl[v].ea0);
         chk($sformatf("table %0d rdb u0", v), cap_b[0], tbl[v].eb0);
         chk($sformatf("table %0d rda u1", v), cap_a[1], tbl[v].ea1);
      end

      // Registered reads: data one cycle late, reset zeroes the read register
      cycle(1'b0, 1'b1, 4'd2, 8'h11, 4'd2, 4'd2, 1'b0);
      chk("u0 same-cycle bypass 0x11", cap_a[0], 8'h11);
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd2, 4'd2, 1'b0);
      chk("u2 registered read 0x11", cap_a[2], 8'h11);
      cycle(1'b1, 1'b0, 4'd0, 8'h00, 4'd2, 4'd2, 1'b0);
      chk("u2 read reg before reset", cap_a[2], 8'h11);
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd2, 4'd2, 1'b0);
      chk("u2 read reg after reset", cap_a[2], 8'h00);

      // Zero register ignores writes and bypass
      cycle(1'b0, 1'b1, 4'd0, 8'hFF, 4'd0, 4'd0, 1'b0);
      chk("u3 r0 bypass", cap_a[3], 8'h00);
      chk("u0 entry0 bypass", cap_a[0], 8'hFF);
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0);
      chk("u3 r0 stored", cap_a[3], 8'h00);

      // Full sweep timing
      fill();
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1);
      busy_cnt = 0; done_cnt = 0; done_at = 0;
      for (int t = 1; t <= 19; t++) begin
         cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd5, 4'd9, 1'b0);
         if (cap_busy[0]) busy_cnt++;
         if (cap_done[0]) begin done_cnt++; done_at = t; end
      end
      chk("sweep busy cycles", 8'(busy_cnt), 8'd16);
      chk("sweep done cycle", 8'(done_at), 8'd17);
      chk("sweep done pulses", 8'(done_cnt), 8'd1);
      for (int a = 0; a < 16; a++) begin
         cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'(a), 4'(a), 1'b0);
         chk($sformatf("cleared entry %0d", a), cap_a[0], 8'h00);
      end

      // Writes racing the sweep, plus a second request that must be ignored
      fill();
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1);
      busy_cnt = 0; done_cnt = 0;
      for (int t = 1; t <= 20; t++) begin
         if (t == 6)      cycle(1'b0, 1'b1, 4'd5, 8'hAA, 4'd5, 4'd2, 1'b0);
         else if (t == 7) cycle(1'b0, 1'b1, 4'd2, 8'hBB, 4'd5, 4'd2, 1'b0);
         else if (t == 8) cycle(1'b0, 1'b1, 4'd9, 8'hCC, 4'd9, 4'd2, 1'b1);
         else             cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd9, 4'd5, 1'b0);
         if (cap_busy[0]) busy_cnt++;
         if (cap_done[0]) done_cnt++;
      end
      chk("race busy cycles", 8'(busy_cnt), 8'd16);
      chk("race done pulses", 8'(done_cnt), 8'd1);
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd5, 4'd2, 1'b0);
      chk("race entry5 kept", cap_a[0], 8'hAA);
      chk("race entry2 kept", cap_b[0], 8'hBB);
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd9, 4'd9, 1'b0);
      chk("race entry9 zeroed", cap_a[0], 8'h00);

      // Reset mid-sweep at ptr=8
      fill();
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1);
      for (int t = 1; t <= 8; t++) cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'd12, 4'd15, 1'b0);
      cycle(1'b1, 1'b0, 4'd0, 8'h00, 4'd12, 4'd15, 1'b0);
      chk("busy before abort", 8'(cap_busy[0]), 8'd1);
      busy_cnt = 0; done_cnt = 0;
      for (int a = 0; a < 20; a++) begin
         cycle(1'b0, 1'b0, 4'd0, 8'h00, 4'(a), 4'(a), 1'b0);
         if (cap_busy[0]) busy_cnt++;
         if (cap_done[0]) done_cnt++;
         if (a < 16) chk($sformatf("abort entry %0d", a), cap_a[0], 8'h00);
      end
      chk("abort busy cycles", 8'(busy_cnt), 8'd0);
      chk("abort done pulses", 8'(done_cnt), 8'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         logic [3:0] wa;
         wa = 4'($urandom_range(15));
         cycle(($urandom_range(149) == 0), 1'($urandom_range(1)), wa, 8'($urandom_range(255)),
               ($urandom_range(2) == 0) ? wa : 4'($urandom_range(15)),
               ($urandom_range(2) == 0) ? wa : 4'($urandom_range(15)),
               ($urandom_range(24) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_reg_file_mp

`default_nettype wire
